// File: rtl/conv3x3_window_gen_if.sv
// +-----------------------------------------------------------------------------+
// | conv3x3_window_gen_if : pixel-in / window-out bundle of conv3x3_window_gen |
// | Optional macro CONV_WIN_COORD_EN adds oWinRow/oWinCol/oPhase.              |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface conv3x3_window_gen_if #(
   parameter int WI = 8
);
   logic            iPixValid;
   logic [WI-1:0]   iPixData;
   logic            oPixReady;
   logic            oInValid;
   logic            oMapDone;
   logic [3*WI-1:0] oWindowRow1;
   logic [3*WI-1:0] oWindowRow2;
   logic [3*WI-1:0] oWindowRow3;
   logic            oBusy;
`ifdef CONV_WIN_COORD_EN
   logic [7:0]      oWinRow;
   logic [7:0]      oWinCol;
   logic [1:0]      oPhase;

   modport slave (
      input  iPixValid, iPixData,
      output oPixReady, oInValid, oMapDone,
      output oWindowRow1, oWindowRow2, oWindowRow3, oBusy,
      output oWinRow, oWinCol, oPhase
   );

   modport master (
      output iPixValid, iPixData,
      input  oPixReady, oInValid, oMapDone,
      input  oWindowRow1, oWindowRow2, oWindowRow3, oBusy,
      input  oWinRow, oWinCol, oPhase
   );
`else
   modport slave (
      input  iPixValid, iPixData,
      output oPixReady, oInValid, oMapDone,
      output oWindowRow1, oWindowRow2, oWindowRow3, oBusy
   );

   modport master (
      output iPixValid, iPixData,
      input  oPixReady, oInValid, oMapDone,
      input  oWindowRow1, oWindowRow2, oWindowRow3, oBusy
   );
`endif
endinterface

`default_nettype wire

// File: rtl/conv3x3_window_gen.sv
// +-----------------------------------------------------------------------------+
// | conv3x3_window_gen : frame store + NPHASE replays as valid 3x3 windows     |
// | Optional macro CONV_WIN_COORD_EN adds window coordinates and phase index.  |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module conv3x3_window_gen #(
   parameter int WI     = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int NPHASE = 4
) (
   input wire                  iClk,
   input wire                  iRsn,
   conv3x3_window_gen_if.slave bus
);

   localparam int C_NPIX = IMG_W * IMG_H;
   localparam int C_AW   = $clog2(C_NPIX);
   localparam int C_RCW  = $clog2(C_NPIX + 2);
   localparam int C_XW   = $clog2(IMG_W);
   localparam int C_YW   = $clog2(IMG_H);
   localparam int C_PW   = (NPHASE > 1) ? $clog2(NPHASE) : 1;

   localparam logic [C_AW-1:0]  C_LAST_WR   = C_AW'(C_NPIX - 1);
   localparam logic [C_RCW-1:0] C_LAST_RD   = C_RCW'(C_NPIX - 1);
   localparam logic [C_RCW-1:0] C_RD_END    = C_RCW'(C_NPIX + 1);
   localparam logic [C_XW-1:0]  C_LAST_X    = C_XW'(IMG_W - 1);
   localparam logic [C_PW-1:0]  C_LAST_PASS = C_PW'(NPHASE - 1);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q;
   logic [C_AW-1:0]  wr_cnt_q;
   logic [C_RCW-1:0] rd_cnt_q;
   logic [C_XW-1:0]  rd_x_q;
   logic [C_YW-1:0]  rd_y_q;
   logic [C_PW-1:0]  pass_q;
   logic             pix_ready_q;
   logic             map_done_q;
   logic             busy_q;

   logic             pix_acc_d;
   logic             rd_en_d;

   logic [WI-1:0]    frame_mem [C_NPIX];
   logic [WI-1:0]    rd_data_q;

   logic             s1_valid_q;
   logic [C_XW-1:0]  s1_x_q;
   logic [C_YW-1:0]  s1_y_q;

   logic [WI-1:0]    lb_top [IMG_W];
   logic [WI-1:0]    lb_mid [IMG_W];
   logic [3*WI-1:0]  col0_q;
   logic [3*WI-1:0]  col1_q;

   logic [WI-1:0]    top_d;
   logic [WI-1:0]    mid_d;
   logic [WI-1:0]    bot_d;
   logic             win_ok_d;

   logic             in_valid_q;
   logic [3*WI-1:0]  row1_q;
   logic [3*WI-1:0]  row2_q;
   logic [3*WI-1:0]  row3_q;

   assign pix_acc_d = bus.iPixValid && pix_ready_q;
   assign rd_en_d   = (state_q == S_RUN) && (rd_cnt_q <= C_LAST_RD);

   // rd_cnt keeps counting past the last read so the 2-cycle pipeline drains in RUN
   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         state_q     <= S_LOAD;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         rd_x_q      <= '0;
         rd_y_q      <= '0;
         pass_q      <= '0;
         pix_ready_q <= 1'b1;
         map_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         map_done_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (pix_acc_d) begin
                  wr_cnt_q <= wr_cnt_q + C_AW'(1);
                  if (wr_cnt_q == C_LAST_WR) begin
                     wr_cnt_q    <= '0;
                     pix_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                     pass_q      <= '0;
                     rd_cnt_q    <= '0;
                     rd_x_q      <= '0;
                     rd_y_q      <= '0;
                     state_q     <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               rd_cnt_q <= rd_cnt_q + C_RCW'(1);
               if (rd_en_d) begin
                  if (rd_x_q == C_LAST_X) begin
                     rd_x_q <= '0;
                     rd_y_q <= rd_y_q + C_YW'(1);
                  end else begin
                     rd_x_q <= rd_x_q + C_XW'(1);
                  end
               end
               if (rd_cnt_q == C_RD_END) begin
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               map_done_q <= 1'b1;
               state_q    <= S_DONE;
            end
            S_DONE: begin
               if (pass_q != C_LAST_PASS) begin
                  pass_q   <= pass_q + C_PW'(1);
                  rd_cnt_q <= '0;
                  rd_x_q   <= '0;
                  rd_y_q   <= '0;
                  state_q  <= S_RUN;
               end else begin
                  wr_cnt_q    <= '0;
                  pix_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_LOAD;
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (pix_acc_d) begin
         frame_mem[wr_cnt_q] <= bus.iPixData;
      end
      if (rd_en_d) begin
         rd_data_q <= frame_mem[rd_cnt_q[C_AW-1:0]];
      end
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
      end else begin
         s1_valid_q <= rd_en_d;
         if (rd_en_d) begin
            s1_x_q <= rd_x_q;
            s1_y_q <= rd_y_q;
         end
      end
   end

   always_comb begin
      top_d    = lb_top[s1_x_q];
      mid_d    = lb_mid[s1_x_q];
      bot_d    = rd_data_q;
      win_ok_d = s1_valid_q && (s1_x_q >= C_XW'(2)) && (s1_y_q >= C_YW'(2));
   end

   // Columns always shift, so at x=0/1 the window refills from the new row before it is used
   always_ff @(posedge iClk) begin
      if (s1_valid_q) begin
         lb_top[s1_x_q] <= mid_d;
         lb_mid[s1_x_q] <= bot_d;
         col0_q         <= col1_q;
         col1_q         <= {top_d, mid_d, bot_d};
      end
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         in_valid_q <= 1'b0;
         row1_q     <= '0;
         row2_q     <= '0;
         row3_q     <= '0;
      end else begin
         in_valid_q <= win_ok_d;
         if (win_ok_d) begin
            row1_q <= {col0_q[3*WI-1 -: WI], col1_q[3*WI-1 -: WI], top_d};
            row2_q <= {col0_q[2*WI-1 -: WI], col1_q[2*WI-1 -: WI], mid_d};
            row3_q <= {col0_q[WI-1:0],       col1_q[WI-1:0],       bot_d};
         end
      end
   end

`ifdef CONV_WIN_COORD_EN
   logic [7:0] win_row_q;
   logic [7:0] win_col_q;

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (win_ok_d) begin
         win_row_q <= 8'(s1_y_q - C_YW'(2));
         win_col_q <= 8'(s1_x_q - C_XW'(2));
      end
   end

   assign bus.oWinRow = win_row_q;
   assign bus.oWinCol = win_col_q;
   assign bus.oPhase  = 2'(pass_q);
`endif

   assign bus.oPixReady   = pix_ready_q;
   assign bus.oInValid    = in_valid_q;
   assign bus.oMapDone    = map_done_q;
   assign bus.oWindowRow1 = row1_q;
   assign bus.oWindowRow2 = row2_q;
   assign bus.oWindowRow3 = row3_q;
   assign bus.oBusy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_window_gen.sv
// +-----------------------------------------------------------------------------+
// | tb_conv3x3_window_gen : directed self-checking bench for conv3x3_window_gen|
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_conv3x3_window_gen;

   localparam int WI   = 8;
   localparam int W    = 28;
   localparam int H    = 28;
   localparam int NP   = 4;
   localparam int NPIX = W * H;
   localparam int NWIN = (W - 2) * (H - 2);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv3x3_window_gen_if #(.WI(WI)) bus ();

   conv3x3_window_gen #(
      .WI(WI), .IMG_W(W), .IMG_H(H), .NPHASE(NP)
   ) dut (
      .iClk(clk),
      .iRsn(rst_n),
      .bus (bus)
   );

   logic [7:0] frame [NPIX];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] exp_row(input int r, input int c);
      return {frame[r*W+c], frame[r*W+c+1], frame[r*W+c+2]};
   endfunction

   // Stream monitor: compares every window to the model frame in raster window order
   int exp_r, exp_c, win_cnt, win_bad, hold_bad, ovl_bad, gap_bad, md_wide, coord_bad;
   int md_cnt = 0;
   int snap_win, snap_bad;
   logic [23:0] last1, last2, last3, snap1, snap2, snap3;
   logic prev1, prev2, prev_md;

   initial begin
      hold_bad = 0; ovl_bad = 0; gap_bad = 0; md_wide = 0; coord_bad = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_r = 0; exp_c = 0; win_cnt = 0; win_bad = 0;
         last1 = '0; last2 = '0; last3 = '0;
         prev1 = 1'b0; prev2 = 1'b0; prev_md = 1'b0;
      end else begin
         if (bus.oInValid && bus.oMapDone) ovl_bad++;
         if (bus.oInValid) begin
            if (exp_r > H - 3) win_bad++;
            else if ({bus.oWindowRow1, bus.oWindowRow2, bus.oWindowRow3} !==
                     {exp_row(exp_r, exp_c), exp_row(exp_r+1, exp_c), exp_row(exp_r+2, exp_c)})
               win_bad++;
`ifdef CONV_WIN_COORD_EN
            if (bus.oWinRow != 8'(exp_r) || bus.oWinCol != 8'(exp_c)) coord_bad++;
`endif
            win_cnt++;
            exp_c++;
            if (exp_c == W - 2) begin exp_c = 0; exp_r++; end
            last1 = bus.oWindowRow1; last2 = bus.oWindowRow2; last3 = bus.oWindowRow3;
         end else if ({bus.oWindowRow1, bus.oWindowRow2, bus.oWindowRow3} !== {last1, last2, last3}) begin
            hold_bad++;
         end
         if (bus.oMapDone) begin
            if (prev_md) md_wide++;
            if (!(prev1 == 1'b0 && prev2 == 1'b1)) gap_bad++;
            snap_win = win_cnt; snap_bad = win_bad;
            snap1 = last1; snap2 = last2; snap3 = last3;
            md_cnt++;
            win_cnt = 0; win_bad = 0; exp_r = 0; exp_c = 0;
         end
         prev2 = prev1; prev1 = bus.oInValid; prev_md = bus.oMapDone;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic fill_frame(input int pat);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            frame[r*W+c] = (pat == 0) ? 8'((r*28 + c) & 8'h7F) : 8'(((r*13 + c*7) & 8'hFF) ^ 8'h5A);
   endtask

   task automatic load(input bit gapped, output bit ok);
      int  i   = 0;
      int  cyc = 0;
      bit  ph  = 1'b0;
      bit  acc;
      while (i < NPIX && cyc < 4*NPIX) begin
         bus.iPixValid = gapped ? ph : 1'b1;
         ph = ~ph;
         bus.iPixData = bus.iPixValid ? frame[i] : 8'hFF;
         acc = bus.iPixValid && bus.oPixReady;
         tick();
         cyc++;
         if (acc) i++;
      end
      bus.iPixValid = 1'b0;
      ok = (i == NPIX);
   endtask

   task automatic wait_md(input int target, output bit ok);
      int n = 0;
      while (md_cnt < target && n < 3000) begin
         tick();
         n++;
      end
      ok = (md_cnt >= target);
   endtask

   task automatic check_pass(input string tag, input int target);
      bit ok;
      wait_md(target, ok);
      check_eq({tag, "_mapdone_seen"}, 64'(ok), 64'd1);
      check_eq({tag, "_win_count"}, 64'(snap_win), 64'(NWIN));
      check_eq({tag, "_win_mismatch"}, 64'(snap_bad), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      int md_base;
      bus.iPixValid = 1'b0;
      bus.iPixData  = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_pixready", 64'(bus.oPixReady), 64'd1);
      check_eq("rst_invalid",  64'(bus.oInValid),  64'd0);
      check_eq("rst_mapdone",  64'(bus.oMapDone),  64'd0);
      check_eq("rst_rows", {16'd0, bus.oWindowRow1 | bus.oWindowRow2 | bus.oWindowRow3}, 64'd0);
      check_eq("rst_busy",     64'(bus.oBusy),     64'd0);
      rst_n = 1'b1;
      tick();

      // Continuous load, first window, then 4 passes with input held high as backpressure
      fill_frame(0);
      load(1'b0, ok);
      check_eq("load0_complete", 64'(ok), 64'd1);
      check_eq("load0_pixready", 64'(bus.oPixReady), 64'd0);
      check_eq("load0_busy",     64'(bus.oBusy),     64'd1);
      md_base = md_cnt;
      n = 0;
      while (!bus.oInValid && n < 200) begin tick(); n++; end
      check_eq("first_win_seen", 64'(bus.oInValid), 64'd1);
      check_eq("first_row1", 64'(bus.oWindowRow1), 64'h000102);
      check_eq("first_row2", 64'(bus.oWindowRow2), 64'h1C1D1E);
      check_eq("first_row3", 64'(bus.oWindowRow3), 64'h38393A);
      bus.iPixValid = 1'b1;
      bus.iPixData  = 8'hFF;
      for (int p = 0; p < NP; p++) begin
         check_pass($sformatf("run0_pass%0d", p), md_base + p + 1);
         if (p == 0) begin
            check_eq("last_row1", 64'(snap1), 64'h555657);
            check_eq("last_row2", 64'(snap2), 64'h717273);
            check_eq("last_row3", 64'(snap3), 64'h0D0E0F);
         end
         if (p < NP - 1) check_eq($sformatf("run0_pass%0d_busy", p), 64'(bus.oPixReady), 64'd0);
      end
      bus.iPixValid = 1'b0;
      check_eq("run0_pixready_after", 64'(bus.oPixReady), 64'd1);
      check_eq("run0_busy_after",     64'(bus.oBusy),     64'd0);

      // Gapped load of the same frame, then abort with reset mid pass 1
      load(1'b1, ok);
      check_eq("load1_complete", 64'(ok), 64'd1);
      md_base = md_cnt;
      check_pass("gapped_pass0", md_base + 1);
      n = 0;
      while (win_cnt < 300 && n < 3000) begin tick(); n++; end
      check_eq("abort_reach_300", 64'(win_cnt >= 300), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_invalid",  64'(bus.oInValid),  64'd0);
      check_eq("abort_mapdone",  64'(bus.oMapDone),  64'd0);
      check_eq("abort_rows", {16'd0, bus.oWindowRow1 | bus.oWindowRow2 | bus.oWindowRow3}, 64'd0);
      check_eq("abort_pixready", 64'(bus.oPixReady), 64'd1);
      check_eq("abort_busy",     64'(bus.oBusy),     64'd0);
      md_base = md_cnt;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (1000) tick();
      check_eq("abort_no_mapdone", 64'(md_cnt), 64'(md_base));
      check_eq("abort_idle_pixready", 64'(bus.oPixReady), 64'd1);

      // Reload a different pattern; all 4 passes must run again from pass 0
      fill_frame(1);
      load(1'b0, ok);
      check_eq("load2_complete", 64'(ok), 64'd1);
      for (int p = 0; p < NP; p++) begin
         check_pass($sformatf("run2_pass%0d", p), md_base + p + 1);
         if (p < NP - 1) check_eq($sformatf("run2_pass%0d_busy", p), 64'(bus.oPixReady), 64'd0);
      end
      check_eq("run2_pixready_after", 64'(bus.oPixReady), 64'd1);

      check_eq("gap_before_mapdone", 64'(gap_bad),  64'd0);
      check_eq("mapdone_one_cycle",  64'(md_wide),  64'd0);
      check_eq("valid_mapdone_ovl",  64'(ovl_bad),  64'd0);
      check_eq("rows_hold_invalid",  64'(hold_bad), 64'd0);
`ifdef CONV_WIN_COORD_EN
      check_eq("coord_mismatch",     64'(coord_bad), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
